// File: rtl/instr_fetch_decode_pkg.sv
// Shared ISA definitions for the fetch/decode front end: opcodes, FSM states
// and the decoded-field record passed from the decoder to the output register.
package instr_fetch_decode_pkg;

  localparam logic [3:0] OP_HALT = 4'b0000;
  localparam logic [3:0] OP_LD   = 4'b0001;
  localparam logic [3:0] OP_ST   = 4'b0010;
  localparam logic [3:0] OP_PUSH = 4'b0100;
  localparam logic [3:0] OP_PULL = 4'b0101;
  localparam logic [3:0] OP_LDG  = 4'b1000;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALTED
  } state_t;

  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] rd;
    logic [3:0] ra;
    logic [7:0] imm;
    logic [3:0] pe;
    logic [1:0] sa_id;
  } dec_fields_t;

  // HALT is recognised here so that it never raises the illegal flag.
  function automatic logic opcode_recognised(input logic [3:0] op);
    return (op == OP_HALT) || (op == OP_LD) || (op == OP_ST) ||
           (op == OP_PUSH) || (op == OP_PULL) || (op == OP_LDG);
  endfunction

endpackage

// File: rtl/instr_fetch_decode_if.sv
// Fetch-side bus: instruction memory read port plus the valid/ready decoded
// instruction channel towards the issue stage.
interface instr_fetch_decode_if #(
  parameter int PC_WIDTH   = 8,
  parameter int INST_WIDTH = 16
);

  logic [PC_WIDTH-1:0]   imem_addr;
  logic [INST_WIDTH-1:0] imem_instr;
  logic                  dec_valid;
  logic                  dec_ready;
  logic [3:0]            dec_opcode;
  logic [3:0]            dec_rd;
  logic [3:0]            dec_ra;
  logic [7:0]            dec_imm;
  logic [3:0]            dec_pe;
  logic [1:0]            dec_sa_id;
  logic [PC_WIDTH-1:0]   dec_pc;
  logic                  dec_illegal;

  modport master (
    output imem_addr,
    input  imem_instr,
    output dec_valid,
    input  dec_ready,
    output dec_opcode, dec_rd, dec_ra, dec_imm, dec_pe, dec_sa_id,
    output dec_pc, dec_illegal
  );

  modport slave (
    input  imem_addr,
    output imem_instr,
    input  dec_valid,
    output dec_ready,
    input  dec_opcode, dec_rd, dec_ra, dec_imm, dec_pe, dec_sa_id,
    input  dec_pc, dec_illegal
  );

endinterface

// File: rtl/instr_field_decode.sv
// Combinational ISA field splitter: one 16-bit word in, per-opcode fields and
// an illegal-opcode flag out. Fields unused by an opcode are forced to zero.
module instr_field_decode
  import instr_fetch_decode_pkg::*;
(
  input  logic [15:0]  instr,
  output dec_fields_t  fields,
  output logic         illegal
);

  always_comb begin
    fields        = '0;
    fields.opcode = instr[15:12];
    fields.rd     = instr[11:8];
    case (instr[15:12])
      OP_LD, OP_ST: begin
        fields.ra  = instr[7:4];
        fields.imm = {4'b0000, instr[3:0]};
      end
      OP_LDG: begin
        fields.imm = instr[7:0];
      end
      OP_PUSH: begin
        fields.pe    = {1'b0, instr[7:5]};
        fields.sa_id = instr[4:3];
      end
      OP_PULL: begin
        fields.pe    = instr[7:4];
        fields.sa_id = instr[3:2];
      end
      default: begin
      end
    endcase
    illegal = !opcode_recognised(instr[15:12]);
  end

endmodule

// File: rtl/instr_fetch_decode.sv
// Fetch/decode front end: PC, IDLE/RUN/HALTED FSM and the registered decode stage.
// Define FETCH_ILLEGAL_TRAP_EN to make illegal opcodes halt fetch like HALT.
module instr_fetch_decode
  import instr_fetch_decode_pkg::*;
#(
  parameter int PC_WIDTH   = 8,
  parameter int INST_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  halted,
  instr_fetch_decode_if.master  bus
);

`ifdef FETCH_ILLEGAL_TRAP_EN
  localparam bit TRAP_ILLEGAL = 1'b1;
`else
  localparam bit TRAP_ILLEGAL = 1'b0;
`endif

  state_t              state_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] dec_pc_q;
  dec_fields_t         dec_q;
  logic                dec_valid_q;
  logic                dec_illegal_q;

  logic [INST_WIDTH-1:0] fetch_word;
  dec_fields_t           word_fields;
  logic                  word_illegal;
  logic                  stop_word;
  logic                  load;

  assign fetch_word = bus.imem_instr;

  instr_field_decode u_field_decode (
    .instr   (fetch_word[15:0]),
    .fields  (word_fields),
    .illegal (word_illegal)
  );

  assign stop_word = (word_fields.opcode == OP_HALT) || (TRAP_ILLEGAL && word_illegal);
  assign load      = !dec_valid_q || bus.dec_ready;

  // A stop word is consumed like any fetch (PC advances past it) but never presented;
  // the load condition guarantees no older instruction is still held at that point.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      dec_pc_q      <= '0;
      dec_q         <= '0;
      dec_valid_q   <= 1'b0;
      dec_illegal_q <= 1'b0;
      halted        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            pc_q    <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (load) begin
            pc_q          <= pc_q + PC_WIDTH'(2);
            dec_illegal_q <= word_illegal;
            if (stop_word) begin
              dec_valid_q <= 1'b0;
              halted      <= 1'b1;
              state_q     <= HALTED;
            end else begin
              dec_valid_q <= 1'b1;
              dec_q       <= word_fields;
              dec_pc_q    <= pc_q;
            end
          end
        end
        HALTED: begin
          if (start) begin
            halted        <= 1'b0;
            pc_q          <= '0;
            dec_valid_q   <= 1'b0;
            dec_illegal_q <= 1'b0;
            state_q       <= RUN;
          end else if (dec_valid_q && bus.dec_ready) begin
            dec_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.dec_valid   = dec_valid_q;
  assign bus.dec_opcode  = dec_q.opcode;
  assign bus.dec_rd      = dec_q.rd;
  assign bus.dec_ra      = dec_q.ra;
  assign bus.dec_imm     = dec_q.imm;
  assign bus.dec_pe      = dec_q.pe;
  assign bus.dec_sa_id   = dec_q.sa_id;
  assign bus.dec_pc      = dec_pc_q;
  assign bus.dec_illegal = dec_illegal_q;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Scoreboard bench for instr_fetch_decode: expected instructions are queued as
// programs are loaded and popped on every accepted valid/ready transfer.
module tb_instr_fetch_decode;
  import instr_fetch_decode_pkg::*;

  typedef struct packed {
    logic [7:0] pc;
    logic [3:0] opcode;
    logic [3:0] rd;
    logic [3:0] ra;
    logic [7:0] imm;
    logic [3:0] pe;
    logic [1:0] sa_id;
    logic       illegal;
  } exp_t;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic start = 1'b0;
  logic halted;

  logic [15:0] mem [0:127];
  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks   = 0;
  int          failures = 0;
  int          accepted = 0;

  instr_fetch_decode_if #(.PC_WIDTH(8), .INST_WIDTH(16)) bus ();

  assign bus.imem_instr = mem[bus.imem_addr[7:1]];

  instr_fetch_decode #(.PC_WIDTH(8), .INST_WIDTH(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .halted (halted),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Reference decode written straight from the ISA field table.
  function automatic exp_t model(input logic [7:0] pc, input logic [15:0] w);
    exp_t e;
    e        = '0;
    e.pc     = pc;
    e.opcode = w[15:12];
    e.rd     = w[11:8];
    case (w[15:12])
      4'h1, 4'h2: begin e.ra = w[7:4]; e.imm = {4'h0, w[3:0]}; end
      4'h8:       e.imm = w[7:0];
      4'h4:       begin e.pe = {1'b0, w[7:5]}; e.sa_id = w[4:3]; end
      4'h5:       begin e.pe = w[7:4]; e.sa_id = w[3:2]; end
      4'h0:       ;
      default:    e.illegal = 1'b1;
    endcase
    return e;
  endfunction

  task automatic push_entry(input logic [7:0] pc, input logic [3:0] op, input logic [3:0] rd,
                            input logic [3:0] ra, input logic [7:0] imm, input logic [3:0] pe,
                            input logic [1:0] sa, input logic ill);
    exp_q.push_back({pc, op, rd, ra, imm, pe, sa, ill});
  endtask

  task automatic apply_stimulus_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_halted(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (halted) break;
      @(posedge clk); #1;
    end
    check_output("halt_seen", {31'b0, halted}, 32'd1);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
  endtask

  always @(negedge clk) begin
    if (!rst && bus.dec_valid && bus.dec_ready) begin
      if (exp_q.size() == 0) begin
        check_output("extra_valid_pc", {24'b0, bus.dec_pc}, 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        accepted++;
        check_output("dec_pc",      {24'b0, bus.dec_pc},      {24'b0, mon_e.pc});
        check_output("dec_opcode",  {28'b0, bus.dec_opcode},  {28'b0, mon_e.opcode});
        check_output("dec_rd",      {28'b0, bus.dec_rd},      {28'b0, mon_e.rd});
        check_output("dec_ra",      {28'b0, bus.dec_ra},      {28'b0, mon_e.ra});
        check_output("dec_imm",     {24'b0, bus.dec_imm},     {24'b0, mon_e.imm});
        check_output("dec_pe",      {28'b0, bus.dec_pe},      {28'b0, mon_e.pe});
        check_output("dec_sa_id",   {30'b0, bus.dec_sa_id},   {30'b0, mon_e.sa_id});
        check_output("dec_illegal", {31'b0, bus.dec_illegal}, {31'b0, mon_e.illegal});
      end
    end
  end

  initial begin
    logic [3:0] ops [0:4];
    ops = '{4'h1, 4'h2, 4'h4, 4'h5, 4'h8};
    bus.dec_ready = 1'b1;
    clear_mem();

    // Reset values, then IDLE must not fetch
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_valid",   {31'b0, bus.dec_valid},   32'd0);
    check_output("rst_addr",    {24'b0, bus.imem_addr},   32'd0);
    check_output("rst_halted",  {31'b0, halted},          32'd0);
    check_output("rst_dec_pc",  {24'b0, bus.dec_pc},      32'd0);
    check_output("rst_opcode",  {28'b0, bus.dec_opcode},  32'd0);
    check_output("rst_illegal", {31'b0, bus.dec_illegal}, 32'd0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("idle_valid", {31'b0, bus.dec_valid}, 32'd0);
    check_output("idle_addr",  {24'b0, bus.imem_addr}, 32'd0);

    // LD / LDG / HALT with a 3-cycle stall on the LDG
    mem[0] = 16'h1234; mem[1] = 16'h85A7; mem[2] = 16'h0000;
    push_entry(8'h00, 4'h1, 4'h2, 4'h3, 8'h04, 4'h0, 2'd0, 1'b0);
    push_entry(8'h02, 4'h8, 4'h5, 4'h0, 8'hA7, 4'h0, 2'd0, 1'b0);
    apply_stimulus_start();
    check_output("start_addr",  {24'b0, bus.imem_addr}, 32'd0);
    check_output("start_valid", {31'b0, bus.dec_valid}, 32'd0);
    @(posedge clk); #1;
    check_output("first_valid", {31'b0, bus.dec_valid}, 32'd1);
    check_output("first_addr",  {24'b0, bus.imem_addr}, 32'd2);
    @(posedge clk); #1;
    bus.dec_ready = 1'b0;
    check_output("second_pc", {24'b0, bus.dec_pc}, 32'd2);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check_output("hold_valid",  {31'b0, bus.dec_valid},  32'd1);
      check_output("hold_addr",   {24'b0, bus.imem_addr},  32'd4);
      check_output("hold_pc",     {24'b0, bus.dec_pc},     32'd2);
      check_output("hold_opcode", {28'b0, bus.dec_opcode}, 32'd8);
      check_output("hold_imm",    {24'b0, bus.dec_imm},    32'hA7);
    end
    bus.dec_ready = 1'b1;
    wait_halted(20);
    check_output("halt1_addr",  {24'b0, bus.imem_addr}, 32'd6);
    check_output("halt1_valid", {31'b0, bus.dec_valid}, 32'd0);
    check_output("halt1_drain", exp_q.size(), 32'd0);

    // PUSH / PULL, restarted from HALTED
    mem[0] = 16'h4ABC; mem[1] = 16'h5A7C; mem[2] = 16'h0000;
    push_entry(8'h00, 4'h4, 4'hA, 4'h0, 8'h00, 4'h5, 2'd3, 1'b0);
    push_entry(8'h02, 4'h5, 4'hA, 4'h0, 8'h00, 4'h7, 2'd3, 1'b0);
    apply_stimulus_start();
    check_output("restart_halted", {31'b0, halted}, 32'd0);
    wait_halted(20);
    check_output("halt2_addr",  {24'b0, bus.imem_addr}, 32'd6);
    check_output("halt2_drain", exp_q.size(), 32'd0);

    // Illegal opcode 0xF000
    mem[0] = 16'hF000; mem[1] = 16'h1234; mem[2] = 16'h0000;
`ifdef FETCH_ILLEGAL_TRAP_EN
    apply_stimulus_start();
    wait_halted(20);
    check_output("trap_addr",    {24'b0, bus.imem_addr},   32'd2);
    check_output("trap_illegal", {31'b0, bus.dec_illegal}, 32'd1);
    check_output("trap_valid",   {31'b0, bus.dec_valid},   32'd0);
`else
    push_entry(8'h00, 4'hF, 4'h0, 4'h0, 8'h00, 4'h0, 2'd0, 1'b1);
    push_entry(8'h02, 4'h1, 4'h2, 4'h3, 8'h04, 4'h0, 2'd0, 1'b0);
    apply_stimulus_start();
    wait_halted(20);
    check_output("illegal_addr", {24'b0, bus.imem_addr}, 32'd6);
`endif
    check_output("illegal_drain", exp_q.size(), 32'd0);

    // 128 non-HALT words with random stalls: PC wraps, mid-run start ignored, then reset
    for (int i = 0; i < 128; i++) begin
      mem[i] = {ops[$urandom_range(0, 4)], 12'($urandom)};
    end
    for (int i = 0; i < 140; i++) begin
      exp_q.push_back(model(8'((i * 2) % 256), mem[i % 128]));
    end
    accepted = 0;
    apply_stimulus_start();
    for (int k = 0; k < 2000; k++) begin
      @(posedge clk); #1;
      bus.dec_ready = ($urandom_range(0, 3) != 0);
      start = (k == 50);
      if (accepted >= 132) break;
    end
    start = 1'b0;
    check_output("wrap_accepts", {31'b0, accepted >= 132}, 32'd1);
    rst = 1'b1;
    #1;
    check_output("midrst_valid",  {31'b0, bus.dec_valid}, 32'd0);
    check_output("midrst_addr",   {24'b0, bus.imem_addr}, 32'd0);
    check_output("midrst_halted", {31'b0, halted},        32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    bus.dec_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check_output("post_rst_idle_valid", {31'b0, bus.dec_valid}, 32'd0);
      check_output("post_rst_idle_addr",  {24'b0, bus.imem_addr}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_decode.md
# instr_fetch_decode

Fetch/decode front end of the compute unit. Drives the byte-addressed PC into the instruction memory and takes back the 16-bit word on the same cycle. Splits each word into opcode, register, immediate, PE and systolic-array fields per the ISA, and hands one decoded instruction per cycle to the issue stage over a valid/ready handshake. Stops on HALT and restarts on `start`.

## Interface
- `PC_WIDTH`, 8: PC / memory address width (byte address, always even)
- `INST_WIDTH`, 16: instruction width; decode field positions are fixed for 16
- `clk` in 1: sole clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `start` in 1: one-cycle pulse; leaves IDLE/HALTED and begins fetching at PC 0
- `imem_addr` out PC_WIDTH: read address to instruction memory (= PC register)
- `imem_instr` in INST_WIDTH: combinational read data for `imem_addr`
- `dec_valid` out 1: decoded instruction held on `dec_*`
- `dec_ready` in 1: issue stage accepts when `dec_valid && dec_ready`
- `dec_opcode` out 4: instr[15:12]
- `dec_rd` out 4: destination/source register, instr[11:8]
- `dec_ra` out 4: address register (LD/ST), instr[7:4]; else 0
- `dec_imm` out 8: LD/ST {4'b0, instr[3:0]}; LDG instr[7:0]; else 0
- `dec_pe` out 4: PUSH {1'b0, instr[7:5]}; PULL instr[7:4]; else 0
- `dec_sa_id` out 2: PUSH instr[4:3]; PULL instr[3:2]; else 0
- `dec_pc` out PC_WIDTH: address the instruction came from
- `dec_illegal` out 1: opcode not in {0001,0010,1000,0100,0101}
- `halted` out 1: HALT (opcode 0000) fetched; fetch stopped

## Operation
- States: IDLE, RUN, HALTED. All outputs are 0 at reset; state resets to IDLE; PC resets to 0.
- IDLE: no fetch. `start` sets PC to 0 and moves to RUN.
- RUN: the output register loads when `!dec_valid || dec_ready`. On a load:
  - capture `imem_instr` and the decoded fields;
  - `dec_pc` <= PC;
  - PC <= PC + 2 (modulo 2^PC_WIDTH, so 0xFE wraps to 0x00 and fetch continues);
  - `dec_valid` <= 1.
- Holding: while `dec_valid && !dec_ready`, the PC and all `dec_*` outputs hold. No instruction is skipped or repeated.
- HALT (opcode 0000):
  - When captured, it is not presented; `dec_valid` <= 0 unless an older instruction is still held.
  - `halted` <= 1 and the state moves to HALTED. The PC freezes at halt address + 2.
- HALTED: a held instruction still drains normally. `start` clears `halted`, sets PC to 0, returns to RUN and drops any undrained instruction.
- `start` in RUN is ignored.
- `rst` mid-stream clears everything immediately, including the held instruction.
- Low bit of PC is always 0.

## Timing
- `start` sampled at edge N -> RUN and `imem_addr` = 0 after N.
- First `dec_valid` = 1 after edge N+1.
- Throughput is 1 instruction/cycle with `dec_ready` tied high.
- Decode latency is one register stage: the fields are registered alongside `dec_valid`.
- `halted` rises on the same edge that captures the HALT word.
- HALT present at address A with `dec_ready` high: the last valid instruction (address A-2) is visible in the cycle before `halted` = 1.

## Configuration
- `FETCH_ILLEGAL_TRAP_EN` defined:
  - an illegal opcode is not presented;
  - it sets `halted` = 1 and `dec_illegal` = 1, and `dec_illegal` stays 1 until `start` or `rst`;
  - the state moves to HALTED, exactly as for HALT.
- Not defined: the illegal instruction is presented with `dec_illegal` = 1 for that instruction only, and fetch continues.

## Structure
- Shared package holds:
  - opcode constants OP_HALT=4'b0000, OP_LD=4'b0001, OP_ST=4'b0010, OP_PUSH=4'b0100, OP_PULL=4'b0101, OP_LDG=4'b1000;
  - the state enum;
  - the decoded-instruction struct type.
- One combinational sub-module, `instr_field_decode`, maps a 16-bit word to the field struct plus the illegal flag. The top holds the FSM, PC and output register.

## Test plan
- Program LD 0x1234, LDG 0x85A7, HALT; `start`, `dec_ready`=1:
  - LD: opcode=1, rd=2, ra=3, imm=0x04, pc=0x00;
  - LDG: rd=5, imm=0xA7, pc=0x02;
  - then `halted`=1, PC=0x06, no third valid.
- PUSH 0x4ABC: rd=0xA, pe=0x5, sa_id=3. PULL 0x5A7C: rd=0xA, pe=0x7, sa_id=3.
- `dec_ready` low 3 cycles on the second instruction: `dec_*` held stable, PC held at 0x04, then resumes with no skip or duplicate.
- Word 0xF000:
  - macro off: presented with `dec_illegal`=1, next instruction follows;
  - macro on: `halted`=1, `dec_illegal`=1, nothing presented.
- 128 non-HALT words: PC goes 0xFE -> 0x00 and the word at 0x00 is re-fetched; `rst` asserted mid-stream clears `dec_valid`, PC and state to IDLE.
